// File: rtl/nonce_search_controller.sv
// Nonce search sequencer: walks a nonce range through an external SHA
// block and stops on the first digest below target, a timeout or an abort.
module nonce_search_controller #(
  parameter int MSG_SIZE       = 640,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic                abort,
  input  logic [MSG_SIZE-1:0] header_in,
  input  logic [255:0]        target,
  input  logic [31:0]         nonce_start,
  input  logic [31:0]         nonce_end,
  input  logic                computationComplete,
  input  logic [255:0]        SHAoutput,
  output logic [MSG_SIZE-1:0] inputMsg,
  output logic                beginComputation,
  output logic                busy,
  output logic                done,
  output logic                found,
  output logic                timeout_err,
  output logic [31:0]         found_nonce,
  output logic [255:0]        found_hash
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    ARM,
    WAIT,
    CHECK,
    FINISH
  } state_t;

  state_t              state;
  logic [MSG_SIZE-33:0] hdr_r;
  logic [255:0]        target_r;
  logic [31:0]         cur_nonce;
  logic [31:0]         end_r;
  logic [CW-1:0]       wait_cnt;
  logic                hit;
  logic                active;

  // The template's nonce field is always overwritten by cur_nonce.
  logic unused_hdr;
  assign unused_hdr = ^header_in[31:0];

  assign hit    = SHAoutput < target_r;
  assign active = (state != IDLE) && (state != FINISH);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state            <= IDLE;
      hdr_r            <= '0;
      target_r         <= '0;
      cur_nonce        <= '0;
      end_r            <= '0;
      wait_cnt         <= '0;
      inputMsg         <= '0;
      beginComputation <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      found            <= 1'b0;
      timeout_err      <= 1'b0;
      found_nonce      <= '0;
      found_hash       <= '0;
    end else begin
      beginComputation <= 1'b0;
      done             <= 1'b0;
      if (active && abort) begin
        state <= FINISH;
        done  <= 1'b1;
        busy  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              hdr_r       <= header_in[MSG_SIZE-1:32];
              target_r    <= target;
              cur_nonce   <= nonce_start;
              end_r       <= nonce_end;
              found       <= 1'b0;
              timeout_err <= 1'b0;
              found_nonce <= '0;
              found_hash  <= '0;
              busy        <= 1'b1;
              state       <= ISSUE;
            end
          end
          ISSUE: begin
            // Only an inverted range can get here with cur_nonce past end.
            if (cur_nonce > end_r) begin
              state <= FINISH;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              inputMsg         <= {hdr_r, cur_nonce};
              beginComputation <= 1'b1;
              wait_cnt         <= '0;
              state            <= ARM;
            end
          end
          ARM: begin
            state <= WAIT;
          end
          WAIT: begin
            if (computationComplete) begin
              state <= CHECK;
            end else if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
              timeout_err <= 1'b1;
              state       <= FINISH;
              done        <= 1'b1;
              busy        <= 1'b0;
            end else begin
              wait_cnt <= wait_cnt + CW'(1);
            end
          end
          CHECK: begin
            if (hit) begin
              found       <= 1'b1;
              found_nonce <= cur_nonce;
              found_hash  <= SHAoutput;
              state       <= FINISH;
              done        <= 1'b1;
              busy        <= 1'b0;
            end else if (cur_nonce == end_r) begin
              state <= FINISH;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              cur_nonce <= cur_nonce + 32'd1;
              state     <= ISSUE;
            end
          end
          FINISH: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nonce_search_controller.sv
// Scoreboard bench for nonce_search_controller with a latency-modelled
// SHA stub; expected issues and completions are queued per directed test.
module tb_nonce_search_controller;

  localparam int MSG     = 64;
  localparam int TMO     = 16;
  localparam int SHA_LAT = 3;

  logic           clk = 1'b0;
  logic           n_rst;
  logic           start;
  logic           abort;
  logic [MSG-1:0] header_in;
  logic [255:0]   target;
  logic [31:0]    nonce_start;
  logic [31:0]    nonce_end;
  logic           computationComplete = 1'b0;
  logic [255:0]   SHAoutput = '0;
  logic [MSG-1:0] inputMsg;
  logic           beginComputation;
  logic           busy;
  logic           done;
  logic           found;
  logic           timeout_err;
  logic [31:0]    found_nonce;
  logic [255:0]   found_hash;

  always #5 clk = ~clk;

  nonce_search_controller #(
    .MSG_SIZE(MSG),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .start(start),
    .abort(abort),
    .header_in(header_in),
    .target(target),
    .nonce_start(nonce_start),
    .nonce_end(nonce_end),
    .computationComplete(computationComplete),
    .SHAoutput(SHAoutput),
    .inputMsg(inputMsg),
    .beginComputation(beginComputation),
    .busy(busy),
    .done(done),
    .found(found),
    .timeout_err(timeout_err),
    .found_nonce(found_nonce),
    .found_hash(found_hash)
  );

  typedef struct {
    bit           is_done;
    logic [31:0]  nonce;
    logic [31:0]  hdr_hi;
    bit           f;
    bit           t;
    logic [31:0]  fn;
    logic [255:0] fh;
    int           gap;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   abort_cyc = 0;
  int   prev_bc_cyc = 0;
  bit   sha_en = 1'b1;
  int   sha_cnt = 0;
  bit   sha_drop = 1'b0;
  logic [31:0] sha_msg = '0;

  // Digest ordering is set by ~nonce, so larger nonces give smaller digests.
  function automatic logic [255:0] dig(input logic [31:0] n);
    return {~n, 192'h0, n};
  endfunction

  task automatic chk(input string name, input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_issue(input logic [31:0] n, input logic [31:0] hh,
                           input int gap);
    exp_t e;
    e.is_done = 1'b0;
    e.nonce   = n;
    e.hdr_hi  = hh;
    e.f       = 1'b0;
    e.t       = 1'b0;
    e.fn      = '0;
    e.fh      = '0;
    e.gap     = gap;
    q.push_back(e);
  endtask

  task automatic exp_done(input bit f, input bit t, input logic [31:0] fn,
                          input logic [255:0] fh, input int gap);
    exp_t e;
    e.is_done = 1'b1;
    e.nonce   = '0;
    e.hdr_hi  = '0;
    e.f       = f;
    e.t       = t;
    e.fn      = fn;
    e.fh      = fh;
    e.gap     = gap;
    q.push_back(e);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // SHA stub: keeps the old result (stale high) through the ARM cycle.
  always @(negedge clk) begin
    if (!n_rst) begin
      computationComplete = 1'b0;
      sha_cnt  = 0;
      sha_drop = 1'b0;
    end else begin
      if (sha_drop) begin
        computationComplete = 1'b0;
        sha_drop = 1'b0;
      end
      if (beginComputation) begin
        sha_cnt  = SHA_LAT;
        sha_drop = 1'b1;
        sha_msg  = inputMsg[31:0];
      end else if (sha_cnt > 0) begin
        sha_cnt--;
        if (sha_cnt == 0 && sha_en) begin
          computationComplete = 1'b1;
          SHAoutput = dig(sha_msg);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (n_rst && (beginComputation || done)) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got bc=%0b done=%0b expected none",
                 beginComputation, done);
      end else begin
        e = q.pop_front();
        chk("event_kind", done, e.is_done);
        if (e.is_done) begin
          chk("found", found, e.f);
          chk("timeout_err", timeout_err, e.t);
          chk("found_nonce", found_nonce, e.fn);
          chk("found_hash", found_hash, e.fh);
          chk("busy_at_done", busy, 0);
        end else begin
          chk("inputMsg", inputMsg, {e.hdr_hi, e.nonce});
          chk("busy_at_issue", busy, 1);
        end
        case (e.gap)
          1: chk("start_latency", cyc - start_cyc, 2);
          2: chk("miss_latency", cyc - prev_bc_cyc, SHA_LAT + 3);
          3: chk("timeout_latency", cyc - prev_bc_cyc, TMO + 1);
          4: chk("abort_latency", cyc - abort_cyc, 1);
          default: ;
        endcase
      end
      if (beginComputation) prev_bc_cyc = cyc;
    end
  end

  task automatic launch(input logic [31:0] s, input logic [31:0] e,
                        input logic [255:0] t, input logic [63:0] h);
    @(negedge clk);
    header_in   = h;
    target      = t;
    nonce_start = s;
    nonce_end   = e;
    start       = 1'b1;
    start_cyc   = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done_seen"}, n < 300, 1);
    repeat (3) @(negedge clk);
    chk({name, "_drained"}, q.size(), 0);
  endtask

  task automatic wait_bc(input string name);
    int n = 0;
    while (beginComputation !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_bc_seen"}, n < 100, 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_inputMsg"}, inputMsg, 0);
    chk({tag, "_bc"}, beginComputation, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_found"}, found, 0);
    chk({tag, "_timeout_err"}, timeout_err, 0);
    chk({tag, "_found_nonce"}, found_nonce, 0);
    chk({tag, "_found_hash"}, found_hash, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] h;
    n_rst       = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    header_in   = '0;
    target      = '0;
    nonce_start = '0;
    nonce_end   = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    n_rst = 1'b1;

    h = 64'hDEAD_BEEF_1234_5678;
    exp_issue(32'd5, h[63:32], 1);
    exp_done(1'b1, 1'b0, 32'd5, dig(32'd5), 0);
    launch(32'd5, 32'd9, '1, h);
    wait_done("first_hit");

    h = 64'h0BAD_F00D_0000_FFFF;
    exp_done(1'b0, 1'b0, 32'd0, '0, 0);
    launch(32'd9, 32'd5, '1, h);
    wait_done("empty_range");

    sha_en = 1'b0;
    h = 64'hA5A5_5A5A_C3C3_3C3C;
    exp_issue(32'd20, h[63:32], 1);
    exp_done(1'b0, 1'b1, 32'd0, '0, 3);
    launch(32'd20, 32'd30, '1, h);
    wait_done("timeout");
    sha_en = 1'b1;

    h = 64'h1111_2222_3333_4444;
    exp_issue(32'd5, h[63:32], 1);
    exp_issue(32'd6, h[63:32], 2);
    exp_issue(32'd7, h[63:32], 2);
    exp_done(1'b0, 1'b0, 32'd0, '0, 0);
    launch(32'd5, 32'd7, '0, h);
    wait_done("full_miss");

    h = 64'hCAFE_0001_9999_8888;
    exp_issue(32'hFFFF_FFFE, h[63:32], 1);
    exp_issue(32'hFFFF_FFFF, h[63:32], 2);
    exp_done(1'b0, 1'b0, 32'd0, '0, 0);
    launch(32'hFFFF_FFFE, 32'hFFFF_FFFF, '0, h);
    wait_done("no_wrap");

    h = 64'h7777_6666_5555_4444;
    exp_issue(32'd5, h[63:32], 1);
    exp_issue(32'd6, h[63:32], 2);
    exp_done(1'b0, 1'b0, 32'd0, '0, 4);
    launch(32'd5, 32'd7, '0, h);
    wait_bc("abort_first");
    @(negedge clk);
    header_in   = ~h;
    nonce_start = 32'd0;
    nonce_end   = 32'hFFFF;
    target      = '1;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_bc("abort_second");
    @(negedge clk);
    abort     = 1'b1;
    abort_cyc = cyc;
    @(negedge clk);
    abort = 1'b0;
    wait_done("abort");
    repeat (20) @(negedge clk);
    chk("abort_quiet_busy", busy, 0);

    h = 64'h2468_ACE0_1357_9BDF;
    exp_issue(32'd5, h[63:32], 1);
    launch(32'd5, 32'd9, '0, h);
    wait_bc("rst_bc");
    @(negedge clk);
    #1 n_rst = 1'b0;
    #1 chk_zero("async_rst");
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (15) @(negedge clk);
    chk("rst_quiet_queue", q.size(), 0);
    chk("rst_quiet_busy", busy, 0);

    h = 64'hFEED_FACE_0F0F_F0F0;
    exp_issue(32'd100, h[63:32], 1);
    for (int n = 101; n <= 104; n++) exp_issue(32'(n), h[63:32], 2);
    exp_done(1'b1, 1'b0, 32'd104, dig(32'd104), 0);
    launch(32'd100, 32'd110, dig(32'd103), h);
    wait_done("strict_less");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nonce_search_controller.md
NONCE_SEARCH_CONTROLLER -- requirements
Module: nonce_search_controller

Interface
REQ-001 Parameter MSG_SIZE, default 640, SHALL set the header/message width in bits.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024, SHALL set the maximum number of WAIT cycles per hash.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low:
clk  in  1  system clock, rising edge
n_rst  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; launch a search (IDLE only)
abort  in  1  level; terminate the current search
header_in  in  MSG_SIZE  header template; nonce field = bits [31:0]
target  in  256  unsigned threshold
nonce_start  in  32  first nonce
nonce_end  in  32  last nonce, inclusive
computationComplete  in  1  from SHA block; level, high while result valid
SHAoutput  in  256  from SHA block; digest
inputMsg  out  MSG_SIZE  to SHA block; header with current nonce
beginComputation  out  1  to SHA block; one-cycle pulse
busy  out  1  search in progress
done  out  1  one-cycle pulse at search end
found  out  1  registered; last search found a hit
timeout_err  out  1  registered; last search ended on a timeout
found_nonce  out  32  registered; winning nonce
found_hash  out  256  registered; winning digest

Function
REQ-004 States SHALL be IDLE, ISSUE, ARM, WAIT, CHECK, FINISH.
REQ-005 In IDLE, start=1 SHALL latch header_in, target, nonce_start and nonce_end; SHALL clear found, timeout_err, found_nonce and found_hash; SHALL set busy; next state ISSUE.
REQ-006 start while busy=1 SHALL be ignored.
REQ-007 If latched nonce_start > nonce_end, the block SHALL go directly to FINISH without asserting beginComputation.
REQ-008 ISSUE SHALL drive inputMsg = {latched header[MSG_SIZE-1:32], cur_nonce} and assert beginComputation for exactly one cycle; next state ARM.
REQ-009 inputMsg SHALL stay stable from ISSUE until CHECK is exited.
REQ-010 ARM SHALL last one cycle with computationComplete ignored, so a stale high level from the previous hash is not accepted; next state WAIT.
REQ-011 WAIT SHALL count cycles.
- computationComplete=1: next state CHECK.
- Count reaches TIMEOUT_CYCLES: set timeout_err; next state FINISH.
REQ-012 CHECK SHALL compare SHAoutput < target as 256-bit unsigned (strict less-than).
- Hit: load found_nonce = cur_nonce, found_hash = SHAoutput, found = 1; next state FINISH.
- Miss with cur_nonce == nonce_end: next state FINISH.
- Otherwise: cur_nonce += 1; next state ISSUE.
REQ-013 The nonce SHALL never wrap: nonce_end = 32'hFFFFFFFF ends the search after that nonce is tested, without incrementing to 0.
REQ-014 abort=1 in any non-IDLE state SHALL go to FINISH on the next edge, ahead of any other transition, with found and timeout_err unchanged.
REQ-015 FINISH SHALL pulse done for one cycle, clear busy, and return to IDLE.
REQ-016 busy SHALL be high from the cycle after start until the FINISH cycle.
REQ-017 Latency: start to first beginComputation SHALL be exactly 2 cycles.
REQ-018 Latency: computationComplete high in WAIT to the next beginComputation SHALL be 2 cycles on a miss.

Reset
REQ-019 n_rst=0 SHALL immediately force state IDLE and drive 0 on every output: inputMsg, beginComputation, busy, done, found, timeout_err, found_nonce and found_hash.
REQ-020 Reset mid-search SHALL discard the search with no done pulse; the first start after reset releases SHALL behave as in REQ-005.

Verification
REQ-021 target=all-ones, nonce 5..9, bench SHA model -> one beginComputation, inputMsg[31:0]=5, found=1, found_nonce=5, done pulse.
REQ-022 target=0, nonce 5..7 -> exactly 3 beginComputation pulses with nonces 5, 6, 7; then done with found=0.
REQ-023 nonce FFFFFFFE..FFFFFFFF, target=0 -> 2 issues, no wrap to 0, done pulse.
REQ-024 SHA stub never asserts computationComplete -> timeout_err=1 and done exactly TIMEOUT_CYCLES cycles after entering WAIT.
REQ-025 abort during the second WAIT, and start pulsed while busy -> done on the next cycle, found=0, start ignored, no further beginComputation.
REQ-026 n_rst asserted in WAIT -> all outputs 0 asynchronously, no done pulse; a new search after release completes correctly.
